// File: rtl/mvu_dsp_sequencer.sv
// mvu_dsp_sequencer: AXI-Stream front end for one PE x SIMD packed MVU compute core.
// Buffers one activation vector and replays it across all neuron folds.
//
// state    | meaning
// S_FILL   | activations come from the stream and are written into the replay buffer
// S_REPLAY | activations come from the replay buffer for neuron folds 1..NF-1
module mvu_dsp_sequencer #(
    parameter int PE               = 2,
    parameter int SIMD             = 2,
    parameter int MW               = 4,
    parameter int MH               = 4,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int ACCU_WIDTH       = 24
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst_n,

    input  logic [SIMD*ACTIVATION_WIDTH-1:0]   s_axis_a_tdata,
    input  logic                               s_axis_a_tvalid,
    output logic                               s_axis_a_tready,

    input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]    s_axis_w_tdata,
    input  logic                               s_axis_w_tvalid,
    output logic                               s_axis_w_tready,

    output logic [PE*ACCU_WIDTH-1:0]           m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,

    output logic                               core_rst,
    output logic                               core_en,
    output logic                               core_last,
    output logic                               core_zero,
    output logic [PE*SIMD*WEIGHT_WIDTH-1:0]    core_w,
    output logic [SIMD*ACTIVATION_WIDTH-1:0]   core_a,
    input  logic                               core_vld,
    input  logic [PE*ACCU_WIDTH-1:0]           core_p
);

    localparam int SF   = MW / SIMD;
    localparam int NF   = MH / PE;
    localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
    localparam int AW   = SIMD * ACTIVATION_WIDTH;
    localparam int PW   = PE * ACCU_WIDTH;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SF_W-1:0] r_sf;
    logic [SF_W-1:0] w_sf_nxt;
    logic [NF_W-1:0] r_nf;
    logic [NF_W-1:0] w_nf_nxt;
    logic [1:0]      r_rst_sync;
    logic            r_m_tvalid;
    logic [PW-1:0]   r_m_tdata;
    logic [AW-1:0]   r_abuf [SF];

    logic w_core_rst;
    logic w_core_en;
    logic w_fill;
    logic w_issue;
    logic w_sf_last;
    logic w_nf_last;

    // Reset asserts asynchronously, releases two clocks after ap_rst_n rises.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_core_rst = ~r_rst_sync[1];
    assign w_core_en  = ~w_core_rst && (~r_m_tvalid || m_axis_tready);
    assign w_fill     = (r_state == S_FILL);
    assign w_issue    = w_core_en && s_axis_w_tvalid && (~w_fill || s_axis_a_tvalid);
    assign w_sf_last  = (r_sf == SF_W'(SF - 1));
    assign w_nf_last  = (r_nf == NF_W'(NF - 1));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_FILL;
            r_sf    <= '0;
            r_nf    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sf    <= w_sf_nxt;
            r_nf    <= w_nf_nxt;
        end
    end

    // A neuron-fold wrap always lands in FILL, so NF=1 never leaves FILL.
    always_comb begin
        w_state_nxt = r_state;
        w_sf_nxt    = r_sf;
        w_nf_nxt    = r_nf;
        if (w_issue) begin
            if (w_sf_last) begin
                w_sf_nxt = '0;
                if (w_nf_last) begin
                    w_nf_nxt    = '0;
                    w_state_nxt = S_FILL;
                end else begin
                    w_nf_nxt    = r_nf + 1'b1;
                    w_state_nxt = S_REPLAY;
                end
            end else begin
                w_sf_nxt = r_sf + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_issue && w_fill) begin
            r_abuf[r_sf] <= s_axis_a_tdata;
        end
    end

    // core_en already implies the output slot is free or being drained this cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else if (w_core_en && core_vld) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= core_p;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign s_axis_w_tready = w_core_en && (~w_fill || s_axis_a_tvalid);
    assign s_axis_a_tready = w_core_en && w_fill && s_axis_w_tvalid;

    assign core_rst  = w_core_rst;
    assign core_en   = w_core_en;
    assign core_zero = w_core_en && ~w_issue;
    assign core_last = w_issue && w_sf_last;
    assign core_w    = s_axis_w_tdata;
    assign core_a    = w_fill ? s_axis_a_tdata : r_abuf[r_sf];

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;

endmodule

// File: tb/tb_mvu_dsp_sequencer.sv
// Directed bench for mvu_dsp_sequencer with a behavioural 5-stage MVU core model.
// Instance u_dut uses SF=2,NF=2; u_dut_sf1 uses SF=1,NF=1.
module tb_mvu_dsp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        sel   = 1'b0;
    logic [15:0] a_tdata  = '0;
    logic        a_tvalid = 1'b0;
    logic [31:0] w_tdata  = '0;
    logic        w_tvalid = 1'b0;
    logic        m_tready = 1'b1;

    logic        a_tready0, w_tready0, m_tvalid0, core_rst0, core_en0, core_last0, core_zero0, core_vld0;
    logic [47:0] m_tdata0, core_p0;
    logic [31:0] core_w0;
    logic [15:0] core_a0;
    logic        a_tready1, w_tready1, m_tvalid1, core_rst1, core_en1, core_last1, core_zero1, core_vld1;
    logic [47:0] m_tdata1, core_p1;
    logic [31:0] core_w1;
    logic [15:0] core_a1;

    mvu_dsp_sequencer u_dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid & ~sel), .s_axis_a_tready(a_tready0),
        .s_axis_w_tdata(w_tdata), .s_axis_w_tvalid(w_tvalid & ~sel), .s_axis_w_tready(w_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .core_rst(core_rst0), .core_en(core_en0), .core_last(core_last0), .core_zero(core_zero0),
        .core_w(core_w0), .core_a(core_a0), .core_vld(core_vld0), .core_p(core_p0)
    );

    mvu_dsp_sequencer #(.MW(2), .MH(2)) u_dut_sf1 (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid & sel), .s_axis_a_tready(a_tready1),
        .s_axis_w_tdata(w_tdata), .s_axis_w_tvalid(w_tvalid & sel), .s_axis_w_tready(w_tready1),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
        .core_rst(core_rst1), .core_en(core_en1), .core_last(core_last1), .core_zero(core_zero1),
        .core_w(core_w1), .core_a(core_a1), .core_vld(core_vld1), .core_p(core_p1)
    );

    // Golden PE x SIMD dot product: weight (pe,s) at bits (pe*2+s)*8, activation s at s*8.
    function automatic logic [47:0] partial(input logic [31:0] w, input logic [15:0] a);
        int s;
        logic [47:0] r;
        r = '0;
        for (int pe = 0; pe < 2; pe++) begin
            s = 0;
            for (int k = 0; k < 2; k++)
                s += int'($signed(w[(pe*2+k)*8 +: 8])) * int'(a[k*8 +: 8]);
            r[pe*24 +: 24] = s[23:0];
        end
        return r;
    endfunction

    function automatic logic [47:0] add_lanes(input logic [47:0] x, input logic [47:0] y);
        logic [47:0] r;
        for (int l = 0; l < 2; l++) r[l*24 +: 24] = x[l*24 +: 24] + y[l*24 +: 24];
        return r;
    endfunction

    function automatic logic [47:0] pk(input int p1, input int p0);
        return {24'(p1), 24'(p0)};
    endfunction

    function automatic logic [15:0] mk_a(input int e0, input int e1);
        return {8'(e1), 8'(e0)};
    endfunction

    function automatic logic [31:0] mk_w(input int pe0, input int pe1);
        return {8'(pe1), 8'(pe1), 8'(pe0), 8'(pe0)};
    endfunction

    // Core models: accumulate, emit on last, 5 pipeline stages, freeze when en=0.
    logic [47:0] c0_acc, c1_acc;
    logic [4:0]  c0_v, c1_v;
    logic [47:0] c0_d [5];
    logic [47:0] c1_d [5];
    logic [47:0] c0_sum, c1_sum;
    assign c0_sum = add_lanes(c0_acc, core_zero0 ? 48'h0 : partial(core_w0, core_a0));
    assign c1_sum = add_lanes(c1_acc, core_zero1 ? 48'h0 : partial(core_w1, core_a1));
    assign core_vld0 = c0_v[4];
    assign core_p0   = c0_d[4];
    assign core_vld1 = c1_v[4];
    assign core_p1   = c1_d[4];

    always @(posedge clk) begin
        if (core_rst0) begin
            c0_acc <= '0;
            c0_v   <= '0;
            for (int k = 0; k < 5; k++) c0_d[k] <= '0;
        end else if (core_en0) begin
            c0_v    <= {c0_v[3:0], core_last0};
            c0_d[0] <= core_last0 ? c0_sum : 48'h0;
            for (int k = 1; k < 5; k++) c0_d[k] <= c0_d[k-1];
            c0_acc  <= core_last0 ? 48'h0 : c0_sum;
        end
    end

    always @(posedge clk) begin
        if (core_rst1) begin
            c1_acc <= '0;
            c1_v   <= '0;
            for (int k = 0; k < 5; k++) c1_d[k] <= '0;
        end else if (core_en1) begin
            c1_v    <= {c1_v[3:0], core_last1};
            c1_d[0] <= core_last1 ? c1_sum : 48'h0;
            for (int k = 1; k < 5; k++) c1_d[k] <= c1_d[k-1];
            c1_acc  <= core_last1 ? 48'h0 : c1_sum;
        end
    end

    logic        obs_a_tready, obs_w_tready, obs_mv, obs_rst, obs_en, obs_last, obs_zero;
    logic [47:0] obs_mdata;
    assign obs_a_tready = sel ? a_tready1  : a_tready0;
    assign obs_w_tready = sel ? w_tready1  : w_tready0;
    assign obs_mv       = sel ? m_tvalid1  : m_tvalid0;
    assign obs_mdata    = sel ? m_tdata1   : m_tdata0;
    assign obs_rst      = sel ? core_rst1  : core_rst0;
    assign obs_en       = sel ? core_en1   : core_en0;
    assign obs_last     = sel ? core_last1 : core_last0;
    assign obs_zero     = sel ? core_zero1 : core_zero0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_a, n_w, n_last, n_zero, n_held;
    int viol_zero, viol_last, viol_pair, viol_stall;
    int first_last, first_v;
    bit timed_out;
    logic [15:0] a_q [$];
    logic [31:0] w_q [$];
    logic [47:0] got [$];

    // Cycle-stepped driver/monitor: inputs change on negedge, handshakes sampled 1ns later.
    task automatic run_stream(input int exp_n, input bit w_toggle, input int a_gap_len,
                              input int hold_start, input int hold_len, input bit a_always,
                              input int drain_n);
        int  a_idx, w_idx, drain;
        bit  a_x, w_x;
        a_idx = 0; w_idx = 0; drain = 0;
        n_a = 0; n_w = 0; n_last = 0; n_zero = 0; n_held = 0;
        viol_zero = 0; viol_last = 0; viol_pair = 0; viol_stall = 0;
        first_last = -1; first_v = -1; timed_out = 1'b1;
        got.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            a_tvalid = a_always || (a_idx < a_q.size() && cyc >= a_gap_len);
            a_tdata  = (a_idx < a_q.size()) ? a_q[a_idx] : 16'h0;
            w_tvalid = (w_idx < w_q.size()) && !(w_toggle && (cyc % 2 == 1));
            w_tdata  = w_tvalid ? w_q[w_idx] : $urandom();
            m_tready = !(cyc >= hold_start && cyc < hold_start + hold_len);
            #1;
            a_x = a_tvalid && obs_a_tready;
            w_x = w_tvalid && obs_w_tready;
            if (obs_zero && w_idx < w_q.size()) n_zero++;
            if (obs_zero !== (obs_en && !w_x)) viol_zero++;
            if (obs_last && !w_x) viol_last++;
            if (a_x && !w_x) viol_pair++;
            if (obs_last) begin
                n_last++;
                if (first_last < 0) first_last = cyc;
            end
            if (a_x) begin a_idx++; n_a++; end
            if (w_x) begin w_idx++; n_w++; end
            if (obs_mv && first_v < 0) first_v = cyc;
            if (obs_mv && !m_tready) begin
                n_held++;
                if (obs_en || obs_a_tready || obs_w_tready) viol_stall++;
            end
            if (obs_mv && m_tready) got.push_back(obs_mdata);
            if (a_idx >= a_q.size() && w_idx >= w_q.size() && got.size() >= exp_n) begin
                drain++;
                if (drain >= drain_n) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        @(negedge clk);
        a_tvalid = 1'b0;
        w_tvalid = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic load_basic();
        a_q = '{mk_a(1, 2), mk_a(3, 4)};
        w_q = '{mk_w(1, 1), mk_w(1, 1), mk_w(1, 1), mk_w(1, 1)};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_tvalid = 1'b1; w_tvalid = 1'b1; m_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (obs_rst !== 1'b1) $display("FAIL rst_core_rst got %b want 1", obs_rst); else n_pass++;
        n_checks++; if (obs_mv !== 1'b0) $display("FAIL rst_tvalid got %b want 0", obs_mv); else n_pass++;
        n_checks++; if (obs_mdata !== 48'h0) $display("FAIL rst_tdata got %h want 0", obs_mdata); else n_pass++;
        n_checks++; if (obs_a_tready !== 1'b0 || obs_w_tready !== 1'b0)
            $display("FAIL rst_tready got a=%b w=%b want 0 0", obs_a_tready, obs_w_tready); else n_pass++;
        n_checks++; if (obs_en !== 1'b0 || obs_zero !== 1'b0 || obs_last !== 1'b0)
            $display("FAIL rst_core_ctl got en=%b zero=%b last=%b want 0 0 0", obs_en, obs_zero, obs_last); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (obs_rst !== 1'b1 || obs_a_tready !== 1'b0)
            $display("FAIL rst_sync1 got core_rst=%b a_tready=%b want 1 0", obs_rst, obs_a_tready); else n_pass++;
        @(negedge clk);
        a_tvalid = 1'b0; w_tvalid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (obs_rst !== 1'b0) $display("FAIL rst_sync2 got core_rst=%b want 0", obs_rst); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        load_basic();
        run_stream(2, 1'b0, 0, 0, 0, 1'b0, 12);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL basic_timeout got %b want 0", timed_out); else n_pass++;
        n_checks++; if (n_a !== 2 || n_w !== 4) $display("FAIL basic_beats got a=%0d w=%0d want 2 4", n_a, n_w); else n_pass++;
        n_checks++; if (got.size() !== 2) $display("FAIL basic_count got %0d want 2", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_checks++; if (got[i] !== pk(10, 10)) $display("FAIL basic_result%0d got %h want %h", i, got[i], pk(10, 10)); else n_pass++;
        end
        n_checks++; if (first_v - first_last !== 6)
            $display("FAIL basic_latency got %0d want 6", first_v - first_last); else n_pass++;
        n_checks++; if (n_last !== 2 || viol_last !== 0 || viol_zero !== 0 || viol_pair !== 0)
            $display("FAIL basic_ctl got last=%0d vl=%0d vz=%0d vp=%0d want 2 0 0 0", n_last, viol_last, viol_zero, viol_pair); else n_pass++;
    endtask

    task automatic test_stall();
        load_basic();
        run_stream(2, 1'b0, 0, 5, 20, 1'b0, 12);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL stall_timeout got %b want 0", timed_out); else n_pass++;
        n_checks++; if (n_held !== 18) $display("FAIL stall_held got %0d want 18", n_held); else n_pass++;
        n_checks++; if (viol_stall !== 0) $display("FAIL stall_en_ready got %0d want 0", viol_stall); else n_pass++;
        n_checks++; if (got.size() !== 2) $display("FAIL stall_count got %0d want 2", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_checks++; if (got[i] !== pk(10, 10)) $display("FAIL stall_result%0d got %h want %h", i, got[i], pk(10, 10)); else n_pass++;
        end
        n_checks++; if (n_a !== 2 || n_w !== 4 || viol_zero !== 0)
            $display("FAIL stall_beats got a=%0d w=%0d vz=%0d want 2 4 0", n_a, n_w, viol_zero); else n_pass++;
    endtask

    task automatic test_gaps();
        logic [47:0] exp_r [2];
        exp_r[0] = pk(-10, 20);
        exp_r[1] = pk(30, 10);
        a_q = '{mk_a(1, 2), mk_a(3, 4)};
        w_q = '{mk_w(2, -1), mk_w(2, -1), mk_w(1, 3), mk_w(1, 3)};
        run_stream(2, 1'b1, 3, 0, 0, 1'b0, 12);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL gaps_timeout got %b want 0", timed_out); else n_pass++;
        n_checks++; if (n_zero !== 7) $display("FAIL gaps_bubbles got %0d want 7", n_zero); else n_pass++;
        n_checks++; if (viol_zero !== 0 || viol_last !== 0)
            $display("FAIL gaps_zero_exact got vz=%0d vl=%0d want 0 0", viol_zero, viol_last); else n_pass++;
        n_checks++; if (got.size() !== 2) $display("FAIL gaps_count got %0d want 2", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_checks++; if (got[i] !== exp_r[i]) $display("FAIL gaps_result%0d got %h want %h", i, got[i], exp_r[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp_r [4];
        exp_r[0] = pk(26, 26);
        exp_r[1] = pk(26, 26);
        exp_r[2] = pk(583, -74624);
        exp_r[3] = pk(583, -74624);
        a_q = '{mk_a(5, 6), mk_a(7, 8), mk_a(200, 255), mk_a(0, 128)};
        w_q = '{mk_w(1, 1), mk_w(1, 1), mk_w(1, 1), mk_w(1, 1),
                mk_w(-128, 1), mk_w(-128, 1), mk_w(-128, 1), mk_w(-128, 1)};
        run_stream(4, 1'b0, 0, 0, 0, 1'b1, 12);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL b2b_timeout got %b want 0", timed_out); else n_pass++;
        n_checks++; if (n_a !== 4) $display("FAIL b2b_replay_a_beats got %0d want 4", n_a); else n_pass++;
        n_checks++; if (n_zero !== 0 || n_last !== 4)
            $display("FAIL b2b_ctl got bubbles=%0d last=%0d want 0 4", n_zero, n_last); else n_pass++;
        n_checks++; if (got.size() !== 4) $display("FAIL b2b_count got %0d want 4", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_checks++; if (got[i] !== exp_r[i]) $display("FAIL b2b_result%0d got %h want %h", i, got[i], exp_r[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        a_q = '{mk_a(9, 9), mk_a(9, 9)};
        w_q = '{mk_w(5, 5), mk_w(5, 5), mk_w(5, 5)};
        run_stream(0, 1'b0, 0, 0, 0, 1'b0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (obs_mv !== 1'b0 || obs_mdata !== 48'h0 || obs_rst !== 1'b1)
            $display("FAIL mid_rst_outputs got tvalid=%b tdata=%h core_rst=%b want 0 0 1", obs_mv, obs_mdata, obs_rst); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_checks++; if (obs_rst !== 1'b1 || obs_en !== 1'b0)
            $display("FAIL mid_rst_hold got core_rst=%b en=%b want 1 0", obs_rst, obs_en); else n_pass++;
        repeat (3) @(negedge clk);
        load_basic();
        run_stream(2, 1'b0, 0, 0, 0, 1'b0, 15);
        n_checks++; if (got.size() !== 2) $display("FAIL mid_rst_count got %0d want 2", got.size()); else n_pass++;
        for (int i = 0; i < got.size() && i < 2; i++) begin
            n_checks++; if (got[i] !== pk(10, 10)) $display("FAIL mid_rst_result%0d got %h want %h", i, got[i], pk(10, 10)); else n_pass++;
        end
    endtask

    task automatic test_sf1();
        logic [47:0] exp_r [$];
        int bad;
        sel = 1'b1;
        a_q.delete();
        w_q.delete();
        for (int i = 0; i < 100; i++) begin
            a_q.push_back(16'($urandom()));
            w_q.push_back($urandom());
            exp_r.push_back(partial(w_q[i], a_q[i]));
        end
        run_stream(100, 1'b0, 0, 0, 0, 1'b0, 12);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL sf1_timeout got %b want 0", timed_out); else n_pass++;
        n_checks++; if (n_last !== 100 || n_w !== 100 || n_a !== 100)
            $display("FAIL sf1_last_every_issue got last=%0d w=%0d a=%0d want 100 100 100", n_last, n_w, n_a); else n_pass++;
        n_checks++; if (got.size() !== 100) $display("FAIL sf1_count got %0d want 100", got.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < got.size() && i < 100; i++) begin
            n_checks++;
            if (got[i] !== exp_r[i]) begin
                bad++;
                if (bad <= 5) $display("FAIL sf1_result%0d got %h want %h", i, got[i], exp_r[i]);
            end else n_pass++;
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_sf1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
